tlu_trigger_receiver: RTL and testbench

TLU_TRIGGER_RECEIVER -- requirements
Module: tlu_trigger_receiver

---
 rtl/tlu_rx_pkg.sv | 15 +
 rtl/tlu_rx_sync.sv | 21 ++
 rtl/tlu_trigger_receiver.sv | 138 +++++++++++++
 tb/tb_tlu_trigger_receiver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_rx_pkg.sv
// Shared state encoding and default parameters for the TLU trigger receiver.
package tlu_rx_pkg;

   localparam int DEF_ID_BITS     = 15;
   localparam int DEF_HALF_PERIOD = 4;
   localparam int DEF_TIMEOUT     = 1024;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HANDSHAKE = 2'd1,
      SHIFT     = 2'd2,
      HOLD      = 2'd3
   } tlu_state_e;

endpackage

// File: rtl/tlu_rx_sync.sv
// Two-flop synchronizer for an asynchronous TLU line, with a rising-edge strobe
// taken from the synchronized level.
module tlu_rx_sync (
   input  logic SYS_CLK,
   input  logic SYS_RST,
   input  logic async_in,
   output logic sync_out,
   output logic rise
);

   logic [2:0] sr;

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) sr <= '0;
      else         sr <= {sr[1:0], async_in};
   end

   assign sync_out = sr[1];
   assign rise     = sr[1] & ~sr[2];

endmodule

// File: rtl/tlu_trigger_receiver.sv
// EUDET-style TLU trigger receiver: busy/handshake, serial trigger-ID readout, valid/ack.
// Optional TLU_RX_TIMESTAMP_EN adds a 32-bit SYS_CLK timestamp captured at trigger accept.
module tlu_trigger_receiver
   import tlu_rx_pkg::*;
#(
   parameter int ID_BITS     = DEF_ID_BITS,
   parameter int HALF_PERIOD = DEF_HALF_PERIOD,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic               SYS_CLK,
   input  logic               SYS_RST,
   input  logic               ENABLE,
   input  logic               TLU_TRIGGER,
   input  logic               TLU_RESET,
   output logic               TLU_BUSY,
   output logic               TLU_CLOCK,
   output logic [ID_BITS-1:0] TRIGGER_ID,
   output logic               TRIGGER_VALID,
   input  logic               TRIGGER_ACK,
   output logic               TIMEOUT_ERR,
   output logic [7:0]         ERR_CNT
`ifdef TLU_RX_TIMESTAMP_EN
   ,
   output logic [31:0]        TIMESTAMP
`endif
);

   localparam int HPW = $clog2(HALF_PERIOD);
   localparam int EW  = $clog2(ID_BITS + 2);
   localparam int TW  = $clog2(TIMEOUT);
   localparam logic [HPW-1:0] HP_LAST   = HPW'(HALF_PERIOD - 1);
   localparam logic [EW-1:0]  EDGE_DATA = EW'(ID_BITS);
   localparam logic [EW-1:0]  EDGE_LAST = EW'(ID_BITS + 1);
   localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);

   tlu_state_e         state, state_nxt;
   logic               trig_s, trig_rise, trst_s, trst_rise, tlu_rst;
   logic [HPW-1:0]     hp_cnt;
   logic [EW-1:0]      edge_cnt;
   logic [TW-1:0]      tmo_cnt;
   logic [ID_BITS-1:0] shreg;
   logic               phase_end, timeout_hit;

   tlu_rx_sync u_sync_trig (
      .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .async_in(TLU_TRIGGER),
      .sync_out(trig_s), .rise(trig_rise)
   );

   tlu_rx_sync u_sync_rst (
      .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .async_in(TLU_RESET),
      .sync_out(trst_s), .rise(trst_rise)
   );

   assign tlu_rst   = trst_s | trst_rise;
   assign phase_end = (hp_cnt == HP_LAST);

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      timeout_hit = 1'b0;
      case (state)
         IDLE:      if (trig_rise && ENABLE) state_nxt = HANDSHAKE;
         HANDSHAKE: begin
            if (!trig_s) state_nxt = SHIFT;
            else if (tmo_cnt == TMO_LAST) begin
               state_nxt   = IDLE;
               timeout_hit = 1'b1;
            end
         end
         SHIFT:     if (phase_end && TLU_CLOCK && edge_cnt == EDGE_LAST) state_nxt = HOLD;
         HOLD:      if (TRIGGER_ACK) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
      if (tlu_rst) begin
         state_nxt   = IDLE;
         timeout_hit = 1'b0;
      end
   end

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         TLU_BUSY      <= 1'b0;
         TLU_CLOCK     <= 1'b0;
         TRIGGER_ID    <= '0;
         TRIGGER_VALID <= 1'b0;
         TIMEOUT_ERR   <= 1'b0;
         ERR_CNT       <= '0;
         hp_cnt        <= '0;
         edge_cnt      <= '0;
         tmo_cnt       <= '0;
         shreg         <= '0;
      end else begin
         TLU_BUSY      <= (state_nxt != IDLE);
         TRIGGER_VALID <= (state_nxt == HOLD);
         TIMEOUT_ERR   <= timeout_hit;
         if (timeout_hit && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;

         if (state == HANDSHAKE) tmo_cnt <= tmo_cnt + 1'b1;
         else                    tmo_cnt <= '0;

         // Serial clock runs only while in SHIFT; data is taken at the end of each high phase.
         if (state == SHIFT && !tlu_rst) begin
            hp_cnt <= phase_end ? '0 : hp_cnt + 1'b1;
            if (phase_end) begin
               TLU_CLOCK <= ~TLU_CLOCK;
               if (!TLU_CLOCK)              edge_cnt <= edge_cnt + 1'b1;
               else if (edge_cnt <= EDGE_DATA) shreg <= {trig_s, shreg[ID_BITS-1:1]};
            end
         end else begin
            hp_cnt    <= '0;
            TLU_CLOCK <= 1'b0;
            edge_cnt  <= '0;
         end

         if (tlu_rst)                                   TRIGGER_ID <= '0;
         else if (state == SHIFT && state_nxt == HOLD)  TRIGGER_ID <= shreg;
      end
   end

`ifdef TLU_RX_TIMESTAMP_EN
   logic [31:0] ts_cnt;

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         ts_cnt    <= '0;
         TIMESTAMP <= '0;
      end else begin
         ts_cnt <= ts_cnt + 32'd1;
         if (state == IDLE && state_nxt == HANDSHAKE) TIMESTAMP <= ts_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_tlu_trigger_receiver.sv
// Directed + randomized bench: the bench plays the TLU, serializing IDs LSB-first on TLU_CLOCK.
module tb_tlu_trigger_receiver;

   localparam int IDB = 15;

   logic           SYS_CLK = 1'b0;
   logic           SYS_RST = 1'b1;
   logic           ENABLE = 1'b0;
   logic           TLU_TRIGGER = 1'b0;
   logic           TLU_RESET = 1'b0;
   logic           TRIGGER_ACK = 1'b0;
   logic           TLU_BUSY, TLU_CLOCK, TRIGGER_VALID, TIMEOUT_ERR;
   logic [IDB-1:0] TRIGGER_ID;
   logic [7:0]     ERR_CNT;
`ifdef TLU_RX_TIMESTAMP_EN
   logic [31:0]    TIMESTAMP;
   int unsigned    cyc;
   always @(posedge SYS_CLK or posedge SYS_RST)
      if (SYS_RST) cyc <= 0;
      else         cyc <= cyc + 1;
`endif

   int checks = 0;
   int failures = 0;

   always #5 SYS_CLK = ~SYS_CLK;

   tlu_trigger_receiver dut (
      .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .ENABLE(ENABLE),
      .TLU_TRIGGER(TLU_TRIGGER), .TLU_RESET(TLU_RESET),
      .TLU_BUSY(TLU_BUSY), .TLU_CLOCK(TLU_CLOCK),
      .TRIGGER_ID(TRIGGER_ID), .TRIGGER_VALID(TRIGGER_VALID), .TRIGGER_ACK(TRIGGER_ACK),
      .TIMEOUT_ERR(TIMEOUT_ERR), .ERR_CNT(ERR_CNT)
`ifdef TLU_RX_TIMESTAMP_EN
      , .TIMESTAMP(TIMESTAMP)
`endif
   );

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge SYS_CLK);
   endtask

   // Raise a trigger, answer BUSY like a TLU and drive ID bits after each TLU_CLOCK rise.
   task automatic tlu_start(input logic [IDB-1:0] id, input int nedges, input bit drop_en,
                            output int edges, output int unsigned busy_cyc);
      int n;
      logic prev;
      edges = 0;
      busy_cyc = 0;
      @(negedge SYS_CLK);
      TLU_TRIGGER = 1'b1;
      n = 0;
      while (!TLU_BUSY && n < 10) begin
         @(negedge SYS_CLK);
         n++;
      end
      chk("busy_on_trigger", TLU_BUSY, 1);
`ifdef TLU_RX_TIMESTAMP_EN
      busy_cyc = cyc - 1;
`endif
      if (drop_en) ENABLE = 1'b0;
      TLU_TRIGGER = 1'b0;
      prev = TLU_CLOCK;
      n = 0;
      while (n < 600 && !TRIGGER_VALID && edges < nedges) begin
         @(negedge SYS_CLK);
         n++;
         if (TLU_CLOCK && !prev) begin
            edges++;
            if (edges <= IDB) TLU_TRIGGER = id[edges-1];
            else              TLU_TRIGGER = 1'b0;
         end
         prev = TLU_CLOCK;
      end
   endtask

   task automatic transact(input logic [IDB-1:0] id, input int ack_dly, input bit drop_en,
                           input bit hold_pulse);
      int edges;
      int unsigned bc;
      tlu_start(id, 1000, drop_en, edges, bc);
      chk("valid_after_shift", TRIGGER_VALID, 1);
      chk("trigger_id", TRIGGER_ID, 32'(id));
      chk("tlu_clock_rises", edges, IDB + 1);
`ifdef TLU_RX_TIMESTAMP_EN
      chk("timestamp", TIMESTAMP, bc);
`endif
      for (int n = 0; n < ack_dly; n++) begin
         @(negedge SYS_CLK);
         if (hold_pulse && n == 10) TLU_TRIGGER = 1'b1;
         if (hold_pulse && n == 15) TLU_TRIGGER = 1'b0;
      end
      if (ack_dly > 0) begin
         chk("valid_held", TRIGGER_VALID, 1);
         chk("id_held", TRIGGER_ID, 32'(id));
         chk("busy_held", TLU_BUSY, 1);
      end
      TRIGGER_ACK = 1'b1;
      @(negedge SYS_CLK);
      TRIGGER_ACK = 1'b0;
      chk("valid_off_after_ack", TRIGGER_VALID, 0);
      chk("busy_off_after_ack", TLU_BUSY, 0);
      if (drop_en) ENABLE = 1'b1;
   endtask

   initial begin
      int n, edges;
      int unsigned bc;
      bit seen;

      cycles(3);
      chk("rst_busy", TLU_BUSY, 0);
      chk("rst_clock", TLU_CLOCK, 0);
      chk("rst_id", TRIGGER_ID, 0);
      chk("rst_valid", TRIGGER_VALID, 0);
      chk("rst_timeout_err", TIMEOUT_ERR, 0);
      chk("rst_err_cnt", ERR_CNT, 0);
      SYS_RST = 1'b0;
      ENABLE = 1'b1;
      cycles(5);

      transact(15'h1234, 3, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++) transact(IDB'(i), 0, 1'b0, 1'b0);
      chk("b2b_err_cnt", ERR_CNT, 0);

      for (int i = 0; i < 5; i++)
         transact(IDB'($urandom), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'b0);

      transact(IDB'($urandom) | 15'h4001, 50, 1'b0, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge SYS_CLK);
         seen |= TLU_BUSY;
      end
      chk("hold_pulse_ignored", seen, 0);

      // Trigger held high: the handshake must abort after the timeout window.
      @(negedge SYS_CLK);
      TLU_TRIGGER = 1'b1;
      n = 0;
      while (!TLU_BUSY && n < 10) begin
         @(negedge SYS_CLK);
         n++;
      end
      chk("timeout_busy", TLU_BUSY, 1);
      n = 0;
      while (!TIMEOUT_ERR && n < 1100) begin
         @(negedge SYS_CLK);
         n++;
      end
      chk("timeout_cycle", n, 1024);
      chk("timeout_busy_low", TLU_BUSY, 0);
      chk("timeout_err_cnt", ERR_CNT, 1);
      @(negedge SYS_CLK);
      chk("timeout_pulse_one_cycle", TIMEOUT_ERR, 0);
      TLU_TRIGGER = 1'b0;
      cycles(5);
      chk("timeout_idle", TLU_BUSY, 0);

      // TLU_RESET after five serial bits.
      tlu_start(15'h7FFF, 5, 1'b0, edges, bc);
      chk("tlurst_edges", edges, 5);
      TLU_RESET = 1'b1;
      TLU_TRIGGER = 1'b0;
      cycles(3);
      chk("tlurst_busy", TLU_BUSY, 0);
      chk("tlurst_clock", TLU_CLOCK, 0);
      chk("tlurst_id", TRIGGER_ID, 0);
      chk("tlurst_valid", TRIGGER_VALID, 0);
      chk("tlurst_err_kept", ERR_CNT, 1);
      seen = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(negedge SYS_CLK);
         seen |= TRIGGER_VALID;
      end
      chk("tlurst_no_valid", seen, 0);
      TLU_RESET = 1'b0;
      cycles(5);
      transact(IDB'($urandom), 2, 1'b0, 1'b0);

      // ENABLE low blocks acceptance.
      ENABLE = 1'b0;
      TLU_TRIGGER = 1'b1;
      cycles(3);
      TLU_TRIGGER = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge SYS_CLK);
         seen |= TLU_BUSY;
      end
      chk("disabled_no_busy", seen, 0);
      ENABLE = 1'b1;
      cycles(3);

      // System reset in the middle of SHIFT.
      tlu_start(15'h5A5A, 6, 1'b0, edges, bc);
      SYS_RST = 1'b1;
      TLU_TRIGGER = 1'b0;
      cycles(2);
      chk("sysrst_busy", TLU_BUSY, 0);
      chk("sysrst_clock", TLU_CLOCK, 0);
      chk("sysrst_err_cnt", ERR_CNT, 0);
      SYS_RST = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge SYS_CLK);
         seen |= TRIGGER_VALID | TLU_BUSY;
      end
      chk("sysrst_no_partial", seen, 0);
      transact(IDB'($urandom), 4, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
